// File: rtl/i2d_imem_wb_pkg.sv
// Shared types, defaults and address helpers for the i2d instruction-memory responder.
package i2d_imem_wb_pkg;

  localparam int DEF_AW          = 10;
  localparam int DEF_WAIT_STATES = 0;

  typedef enum logic [0:0] {
    IMEM_IDLE = 1'b0,
    IMEM_WAIT = 1'b1
  } imem_state_t;

  // Word index of a byte address relative to the memory base; the subtraction wraps.
  function automatic logic [31:0] word_index(input logic [31:0] adr, input logic [31:0] base);
    logic [31:0] offset;
    offset = adr - base;
    return offset >> 2;
  endfunction

endpackage

// File: rtl/i2d_imem_wb_if.sv
// Wishbone fetch bus between the i2d fetch stage (master) and the instruction memory (slave).
interface i2d_imem_wb_if;

  logic [31:0] adr_i;
  logic        stb_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        rty_o;
  logic        err_o;

  modport master (
    output adr_i, stb_i,
    input  dat_o, ack_o, rty_o, err_o
  );

  modport slave (
    input  adr_i, stb_i,
    output dat_o, ack_o, rty_o, err_o
  );

endinterface

// File: rtl/i2d_imem_ram.sv
// Program-word array: one asynchronous read port for fetches, one synchronous write port for loading.
module i2d_imem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [31:0]   wdat,
  input  logic [AW-1:0] radr,
  output logic [31:0]   rdat
);

  logic [31:0] mem [2**AW];

  // NOTE: the array has no reset; program contents survive a system reset and are
  // only changed through the load port.
  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdat;
  end

  assign rdat = mem[radr];

endmodule

// File: rtl/i2d_imem_wb.sv
// Wishbone instruction-memory responder: address check, wait-state FSM and output muxing
// around the program RAM.
module i2d_imem_wb
  import i2d_imem_wb_pkg::*;
#(
  parameter int          AW          = DEF_AW,
  parameter int          WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  i2d_imem_wb_if.slave      bus,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_adr,
  input  logic [31:0]       ld_dat
);

  localparam logic [32:0] DEPTH  = 33'(1) << AW;
  localparam logic [3:0]  RELOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  imem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] last_adr, last_adr_nxt;

  logic [31:0] word_idx;
  logic        adr_err;
  logic        new_req;
  logic        ack, rty, err;
  logic [31:0] rd_data;

  i2d_imem_ram #(.AW(AW)) u_ram (
    .clk  (clk),
    .we   (ld_en),
    .wadr (ld_adr),
    .wdat (ld_dat),
    .radr (word_idx[AW-1:0]),
    .rdat (rd_data)
  );

  // The range test uses the full wrapped difference, so addresses below the base also
  // land far out of range; the explicit below-base compare keeps that intent visible.
  assign word_idx = word_index(bus.adr_i, BASE_ADR);
  assign adr_err  = (bus.adr_i[1:0] != 2'b00)
                 || ({1'b0, word_idx} >= DEPTH)
                 || (bus.adr_i < BASE_ADR);
  assign new_req  = (state == IMEM_IDLE) || (bus.adr_i != last_adr);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_adr_nxt = last_adr;
    ack          = 1'b0;
    rty          = 1'b0;
    err          = 1'b0;

    if (!bus.stb_i) begin
      state_nxt = IMEM_IDLE;
    end else if (adr_err) begin
      err = 1'b1;
    end else if (ld_en) begin
      rty = 1'b1;
    end else if (new_req) begin
      // Fresh address, or a redirect while waiting: restart the wait-state count.
      if (WAIT_STATES == 0) begin
        ack       = 1'b1;
        state_nxt = IMEM_IDLE;
      end else begin
        rty          = 1'b1;
        cnt_nxt      = RELOAD;
        last_adr_nxt = bus.adr_i;
        state_nxt    = IMEM_WAIT;
      end
    end else if (cnt != 4'd0) begin
      rty     = 1'b1;
      cnt_nxt = cnt - 4'd1;
    end else begin
      ack       = 1'b1;
      state_nxt = IMEM_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IMEM_IDLE;
      cnt      <= 4'd0;
      last_adr <= 32'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_adr <= last_adr_nxt;
    end
  end

  // Responses are forced quiet for as long as reset is held, without waiting for a clock.
  assign bus.ack_o = ack & rst;
  assign bus.rty_o = rty & rst;
  assign bus.err_o = err & rst;
  assign bus.dat_o = bus.ack_o ? rd_data : 32'h0;

endmodule

// File: tb/tb_i2d_imem_wb.sv
// Directed bench for i2d_imem_wb: four instances share reset and the load port and differ in
// wait states and base address.
module tb_i2d_imem_wb;
  import i2d_imem_wb_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_adr;
  logic [31:0]   ld_dat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2d_imem_wb_if wb0 ();
  i2d_imem_wb_if wb1 ();
  i2d_imem_wb_if wb2 ();
  i2d_imem_wb_if wb3 ();

  i2d_imem_wb #(.AW(AW), .WAIT_STATES(0), .BASE_ADR(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .bus(wb0.slave), .ld_en(ld_en), .ld_adr(ld_adr), .ld_dat(ld_dat));
  i2d_imem_wb #(.AW(AW), .WAIT_STATES(2), .BASE_ADR(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .bus(wb1.slave), .ld_en(ld_en), .ld_adr(ld_adr), .ld_dat(ld_dat));
  i2d_imem_wb #(.AW(AW), .WAIT_STATES(3), .BASE_ADR(32'h0000_0000)) dut2 (
    .clk(clk), .rst(rst), .bus(wb2.slave), .ld_en(ld_en), .ld_adr(ld_adr), .ld_dat(ld_dat));
  i2d_imem_wb #(.AW(AW), .WAIT_STATES(0), .BASE_ADR(32'h0000_1000)) dut3 (
    .clk(clk), .rst(rst), .bus(wb3.slave), .ld_en(ld_en), .ld_adr(ld_adr), .ld_dat(ld_dat));

  // Flags are packed as {ack, rty, err}.
  function automatic logic [2:0] flags(input int idx);
    case (idx)
      0:       return {wb0.ack_o, wb0.rty_o, wb0.err_o};
      1:       return {wb1.ack_o, wb1.rty_o, wb1.err_o};
      2:       return {wb2.ack_o, wb2.rty_o, wb2.err_o};
      default: return {wb3.ack_o, wb3.rty_o, wb3.err_o};
    endcase
  endfunction

  task automatic idle_all();
    wb0.stb_i = 1'b0; wb0.adr_i = 32'h0;
    wb1.stb_i = 1'b0; wb1.adr_i = 32'h0;
    wb2.stb_i = 1'b0; wb2.adr_i = 32'h0;
    wb3.stb_i = 1'b0; wb3.adr_i = 32'h0;
  endtask

  task automatic load_word(input logic [AW-1:0] adr, input logic [31:0] dat);
    @(negedge clk);
    ld_en = 1'b1; ld_adr = adr; ld_dat = dat;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] f;
    rst = 1'b0; ld_en = 1'b0; ld_adr = '0; ld_dat = 32'h0;
    idle_all();
    @(negedge clk);
    wb0.stb_i = 1'b1; wb0.adr_i = 32'h0;
    #1;
    f = flags(0); checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", f); end
    checks++;
    if (wb0.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 00000000", wb0.dat_o); end
    @(negedge clk);
    rst = 1'b1; wb0.stb_i = 1'b0;
    #1;
    f = flags(0); checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL idle_no_stb: got %b want 000", f); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f;
    load_word(10'd0,    32'h1111_1111);
    load_word(10'd1,    32'h2222_2222);
    load_word(10'd2,    32'h3333_3333);
    load_word(10'd4,    32'h4444_4444);
    load_word(10'd1023, 32'h5A5A_A5A5);
    @(negedge clk);
    wb0.stb_i = 1'b1; wb0.adr_i = 32'h0;
    #1;
    f = flags(0); checks++;
    if (f !== 3'b100) begin errors++; $display("FAIL b2b_w0_flags: got %b want 100", f); end
    checks++;
    if (wb0.dat_o !== 32'h1111_1111) begin errors++; $display("FAIL b2b_w0_dat: got %h want 11111111", wb0.dat_o); end
    @(negedge clk);
    wb0.adr_i = 32'h4;
    #1;
    f = flags(0); checks++;
    if (f !== 3'b100) begin errors++; $display("FAIL b2b_w1_flags: got %b want 100", f); end
    checks++;
    if (wb0.dat_o !== 32'h2222_2222) begin errors++; $display("FAIL b2b_w1_dat: got %h want 22222222", wb0.dat_o); end
    @(negedge clk);
    wb0.stb_i = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [2:0] f;
    logic [2:0] exp_f [4] = '{3'b010, 3'b010, 3'b100, 3'b010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wb1.stb_i = 1'b1; wb1.adr_i = 32'h8;
      #1;
      f = flags(1); checks++;
      if (f !== exp_f[i]) begin errors++; $display("FAIL ws2_cycle%0d_flags: got %b want %b", i, f, exp_f[i]); end
      if (i == 2) begin
        checks++;
        if (wb1.dat_o !== 32'h3333_3333) begin errors++; $display("FAIL ws2_ack_dat: got %h want 33333333", wb1.dat_o); end
      end else begin
        checks++;
        if (wb1.dat_o !== 32'h0) begin errors++; $display("FAIL ws2_cycle%0d_dat: got %h want 00000000", i, wb1.dat_o); end
      end
    end
    @(negedge clk);
    wb1.stb_i = 1'b0;
  endtask

  task automatic test_errors();
    logic [2:0] f;
    logic [31:0] adr0 [3] = '{32'h6, 32'h1000, 32'hFFC};
    logic [2:0]  exp0 [3] = '{3'b001, 3'b001, 3'b100};
    logic [31:0] adr3 [4] = '{32'h1000, 32'hFFC, 32'h1FFC, 32'h2000};
    logic [2:0]  exp3 [4] = '{3'b100, 3'b001, 3'b100, 3'b001};
    logic [31:0] dat3 [4] = '{32'h1111_1111, 32'h0, 32'h5A5A_A5A5, 32'h0};
    logic [31:0] adr1 [4] = '{32'h8, 32'h6, 32'h8, 32'h8};
    logic [2:0]  exp1 [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wb0.stb_i = 1'b1; wb0.adr_i = adr0[i];
      #1;
      f = flags(0); checks++;
      if (f !== exp0[i]) begin errors++; $display("FAIL err_ws0_%h_flags: got %b want %b", adr0[i], f, exp0[i]); end
    end
    checks++;
    if (wb0.dat_o !== 32'h5A5A_A5A5) begin errors++; $display("FAIL top_word_dat: got %h want 5a5aa5a5", wb0.dat_o); end
    @(negedge clk);
    wb0.stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wb3.stb_i = 1'b1; wb3.adr_i = adr3[i];
      #1;
      f = flags(3); checks++;
      if (f !== exp3[i]) begin errors++; $display("FAIL base_%h_flags: got %b want %b", adr3[i], f, exp3[i]); end
      checks++;
      if (wb3.dat_o !== dat3[i]) begin errors++; $display("FAIL base_%h_dat: got %h want %h", adr3[i], wb3.dat_o, dat3[i]); end
    end
    @(negedge clk);
    wb3.stb_i = 1'b0;
    // An error mid-wait must leave the countdown untouched.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wb1.stb_i = 1'b1; wb1.adr_i = adr1[i];
      #1;
      f = flags(1); checks++;
      if (f !== exp1[i]) begin errors++; $display("FAIL err_in_wait_cycle%0d: got %b want %b", i, f, exp1[i]); end
    end
    @(negedge clk);
    wb1.stb_i = 1'b0;
  endtask

  task automatic test_redirect();
    logic [2:0] f;
    logic [31:0] adr [5] = '{32'h0, 32'h10, 32'h10, 32'h10, 32'h10};
    logic [2:0]  exp [5] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wb2.stb_i = 1'b1; wb2.adr_i = adr[i];
      #1;
      f = flags(2); checks++;
      if (f !== exp[i]) begin errors++; $display("FAIL redirect_cycle%0d: got %b want %b", i, f, exp[i]); end
    end
    checks++;
    if (wb2.dat_o !== 32'h4444_4444) begin errors++; $display("FAIL redirect_dat: got %h want 44444444", wb2.dat_o); end
    @(negedge clk);
    wb2.stb_i = 1'b0;
  endtask

  task automatic test_load_busy();
    logic [2:0] f;
    @(negedge clk);
    ld_en = 1'b1; ld_adr = 10'd5; ld_dat = 32'hDEAD_BEEF;
    wb0.stb_i = 1'b1; wb0.adr_i = 32'h14;
    #1;
    f = flags(0); checks++;
    if (f !== 3'b010) begin errors++; $display("FAIL load_busy_flags: got %b want 010", f); end
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    f = flags(0); checks++;
    if (f !== 3'b100) begin errors++; $display("FAIL load_after_flags: got %b want 100", f); end
    checks++;
    if (wb0.dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_after_dat: got %h want deadbeef", wb0.dat_o); end
    @(negedge clk);
    wb0.stb_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [2:0] f;
    logic [2:0] exp [4] = '{3'b010, 3'b010, 3'b010, 3'b100};
    @(negedge clk);
    wb2.stb_i = 1'b1; wb2.adr_i = 32'h8;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    f = flags(2); checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b want 000", f); end
    checks++;
    if (wb2.dat_o !== 32'h0) begin errors++; $display("FAIL async_reset_dat: got %h want 00000000", wb2.dat_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      f = flags(2); checks++;
      if (f !== exp[i]) begin errors++; $display("FAIL post_reset_cycle%0d: got %b want %b", i, f, exp[i]); end
    end
    checks++;
    if (wb2.dat_o !== 32'h3333_3333) begin errors++; $display("FAIL post_reset_dat: got %h want 33333333", wb2.dat_o); end
    @(negedge clk);
    wb2.stb_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_redirect();
    test_load_busy();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
